// File: rtl/ssd_capture.sv
// Seven-segment bus capture: samples the active-low segment/dp/anode lines, decodes
// each settled digit back to BCD and publishes a complete scan as one frame.
module ssd_capture #(
   parameter int N_DIGITS      = 4,
   parameter int SETTLE_CYCLES = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [6:0]            segment_in,
   input  logic                  dp_in,
   input  logic [N_DIGITS-1:0]   an_in,
   input  logic                  clr_err,
   output logic [4*N_DIGITS-1:0] digits_o,
   output logic [N_DIGITS-1:0]   dp_o,
   output logic [N_DIGITS-1:0]   digit_ok_o,
   output logic                  frame_valid_o,
   output logic                  err_o
);

   localparam int         IW       = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
   localparam logic [7:0] SETTLE_L = 8'(SETTLE_CYCLES);

   typedef enum logic [1:0] {IDLE, SETTLE, HOLD} state_t;

   state_t                state_q, state_d;
   logic [6:0]            seg_s_q;
   logic                  dp_s_q;
   logic [N_DIGITS-1:0]   an_s_q;
   logic [IW-1:0]         idx_q, idx_d;
   logic [6:0]            pat_q, pat_d;
   logic                  dpl_q, dpl_d;
   logic [7:0]            cnt_q, cnt_d;
   logic [N_DIGITS-1:0]   seen_q, seen_d;
   logic [4*N_DIGITS-1:0] sh_dig_q, sh_dig_d, digits_q, digits_d;
   logic [N_DIGITS-1:0]   sh_dp_q, sh_dp_d, dp_q, dp_d;
   logic [N_DIGITS-1:0]   sh_ok_q, sh_ok_d, ok_q, ok_d;
   logic                  frame_q, frame_d, err_q, err_d;

   logic [N_DIGITS-1:0]   low;
   logic                  single, blank, multi, same, load, inc, capture;
   logic [IW-1:0]         s_idx;
   logic [4:0]            dec;
   logic [N_DIGITS-1:0]   seen_new;

   // Returns {ok, bcd}; unknown patterns decode to F with ok cleared.
   function automatic logic [4:0] decode(input logic [6:0] p);
      case (p)
         7'b0000001: return {1'b1, 4'd0};
         7'b1001111: return {1'b1, 4'd1};
         7'b0010010: return {1'b1, 4'd2};
         7'b0000110: return {1'b1, 4'd3};
         7'b1001100: return {1'b1, 4'd4};
         7'b0100100: return {1'b1, 4'd5};
         7'b0100000: return {1'b1, 4'd6};
         7'b0001101: return {1'b1, 4'd7};
         7'b0000000: return {1'b1, 4'd8};
         7'b0000100: return {1'b1, 4'd9};
         default:    return {1'b0, 4'hF};
      endcase
   endfunction

   always_comb begin
      // NOTE: every variable gets a default before any branch so no latch is inferred.
      state_d  = state_q;
      idx_d    = idx_q;
      pat_d    = pat_q;
      dpl_d    = dpl_q;
      cnt_d    = cnt_q;
      seen_d   = seen_q;
      sh_dig_d = sh_dig_q;
      sh_dp_d  = sh_dp_q;
      sh_ok_d  = sh_ok_q;
      digits_d = digits_q;
      dp_d     = dp_q;
      ok_d     = ok_q;
      frame_d  = 1'b0;
      load     = 1'b0;
      inc      = 1'b0;
      capture  = 1'b0;
      seen_new = seen_q;

      low    = ~an_s_q;
      single = $onehot(low);
      blank  = (low == '0);
      multi  = !single && !blank;
      s_idx  = '0;
      for (int i = 0; i < N_DIGITS; i++) begin
         if (low[i]) s_idx = IW'(i);
      end
      same = (s_idx == idx_q) && (seg_s_q == pat_q) && (dp_s_q == dpl_q);
      dec  = decode(seg_s_q);

      unique case (state_q)
         IDLE: if (single) load = 1'b1;
         default: begin
            if (!single) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else if (!same) begin
               load = 1'b1;
            end else if (state_q == SETTLE) begin
               inc   = 1'b1;
               cnt_d = (cnt_q >= SETTLE_L) ? cnt_q : cnt_q + 8'd1;
            end
         end
      endcase

      if (load) begin
         idx_d   = s_idx;
         pat_d   = seg_s_q;
         dpl_d   = dp_s_q;
         cnt_d   = 8'd1;
         state_d = SETTLE;
      end

      // A digit is taken on the cycle the counter reaches the settle threshold.
      if ((load || inc) && cnt_d == SETTLE_L) begin
         capture               = 1'b1;
         state_d               = HOLD;
         sh_dig_d[4*s_idx +: 4] = dec[3:0];
         sh_ok_d[s_idx]        = dec[4];
         sh_dp_d[s_idx]        = dp_s_q;
         seen_new              = seen_q | (N_DIGITS'(1) << s_idx);
         if (&seen_new) begin
            digits_d = sh_dig_d;
            dp_d     = sh_dp_d;
            ok_d     = sh_ok_d;
            frame_d  = 1'b1;
            seen_d   = '0;
         end else begin
            seen_d = seen_new;
         end
      end

      if (multi || (capture && !dec[4])) err_d = 1'b1;
      else if (clr_err)                  err_d = 1'b0;
      else                               err_d = err_q;
   end

   // NOTE: sequential state uses non-blocking assignments only, so every flop sees pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         seg_s_q  <= '1;
         dp_s_q   <= 1'b1;
         an_s_q   <= '1;
         state_q  <= IDLE;
         idx_q    <= '0;
         pat_q    <= '0;
         dpl_q    <= 1'b0;
         cnt_q    <= '0;
         seen_q   <= '0;
         sh_dig_q <= '0;
         sh_dp_q  <= '0;
         sh_ok_q  <= '0;
         digits_q <= '0;
         dp_q     <= '0;
         ok_q     <= '0;
         frame_q  <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         seg_s_q  <= segment_in;
         dp_s_q   <= dp_in;
         an_s_q   <= an_in;
         state_q  <= state_d;
         idx_q    <= idx_d;
         pat_q    <= pat_d;
         dpl_q    <= dpl_d;
         cnt_q    <= cnt_d;
         seen_q   <= seen_d;
         sh_dig_q <= sh_dig_d;
         sh_dp_q  <= sh_dp_d;
         sh_ok_q  <= sh_ok_d;
         digits_q <= digits_d;
         dp_q     <= dp_d;
         ok_q     <= ok_d;
         frame_q  <= frame_d;
         err_q    <= err_d;
      end
   end

   assign digits_o      = digits_q;
   assign dp_o          = dp_q;
   assign digit_ok_o    = ok_q;
   assign frame_valid_o = frame_q;
   assign err_o         = err_q;

endmodule

// File: tb/tb_ssd_capture.sv
// Directed and randomized scans of the seven-segment bus, checked against a
// run-level model: a single-anode run of at least SETTLE_CYCLES samples captures.
module tb_ssd_capture;

   localparam int N = 4;
   localparam int S = 4;
   localparam logic [6:0] SEG [10] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                                       7'b1001100, 7'b0100100, 7'b0100000, 7'b0001101,
                                       7'b0000000, 7'b0000100};
   localparam logic [3:0] AN [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

   logic            clk = 1'b0;
   logic            rst_n;
   logic [6:0]      segment_in;
   logic            dp_in;
   logic [N-1:0]    an_in;
   logic            clr_err;
   logic [4*N-1:0]  digits_o;
   logic [N-1:0]    dp_o, digit_ok_o;
   logic            frame_valid_o, err_o;

   ssd_capture #(.N_DIGITS(N), .SETTLE_CYCLES(S)) dut (
      .clk(clk), .rst_n(rst_n), .segment_in(segment_in), .dp_in(dp_in), .an_in(an_in),
      .clr_err(clr_err), .digits_o(digits_o), .dp_o(dp_o), .digit_ok_o(digit_ok_o),
      .frame_valid_o(frame_valid_o), .err_o(err_o)
   );

   always #5 clk = ~clk;

   int vectors = 0, miscompares = 0, pulses = 0;
   always @(negedge clk) if (frame_valid_o === 1'b1) pulses++;

   // Reference model state
   logic [4*N-1:0] m_sh_dig, m_dig;
   logic [N-1:0]   m_sh_dp, m_sh_ok, m_dp, m_ok, m_seen;
   logic           m_err;
   int             m_frames = 0;

   function automatic logic [4:0] ref_decode(input logic [6:0] p);
      for (int k = 0; k < 10; k++) if (SEG[k] == p) return {1'b1, 4'(k)};
      return {1'b0, 4'hF};
   endfunction

   task automatic model_reset();
      m_sh_dig = '0; m_dig = '0; m_sh_dp = '0; m_sh_ok = '0;
      m_dp = '0; m_ok = '0; m_seen = '0; m_err = 1'b0;
   endtask

   task automatic model_run(input logic [N-1:0] an, input logic [6:0] seg, input logic dp,
                            input int len);
      int lows, idx;
      logic [4:0] d;
      lows = $countones(~an);
      idx  = 0;
      for (int i = 0; i < N; i++) if (!an[i]) idx = i;
      if (lows > 1) m_err = 1'b1;
      else if (lows == 1 && len >= S) begin
         d = ref_decode(seg);
         m_sh_dig[4*idx +: 4] = d[3:0];
         m_sh_ok[idx] = d[4];
         m_sh_dp[idx] = dp;
         if (!d[4]) m_err = 1'b1;
         m_seen[idx] = 1'b1;
         if (&m_seen) begin
            m_dig = m_sh_dig; m_dp = m_sh_dp; m_ok = m_sh_ok;
            m_frames++;
            m_seen = '0;
         end
      end
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Drives one run of identical samples starting at a falling edge.
   task automatic drive(input logic [N-1:0] an, input logic [6:0] seg, input logic dp,
                        input int len);
      an_in = an; segment_in = seg; dp_in = dp;
      model_run(an, seg, dp, len);
      repeat (len) @(negedge clk);
   endtask

   task automatic scan_pat(input logic [6:0] p0, p1, p2, p3, input logic [3:0] dpm,
                           input int len);
      drive(AN[0], p0, dpm[0], len);
      drive(AN[1], p1, dpm[1], len);
      drive(AN[2], p2, dpm[2], len);
      drive(AN[3], p3, dpm[3], len);
   endtask

   task automatic phase_check(input string tag);
      drive('1, 7'h7F, 1'b1, 3);
      check({tag, ".frames"}, pulses, m_frames);
      check({tag, ".digits"}, digits_o, m_dig);
      check({tag, ".dp"}, dp_o, m_dp);
      check({tag, ".ok"}, digit_ok_o, m_ok);
      check({tag, ".err"}, err_o, m_err);
   endtask

   task automatic do_reset();
      rst_n = 1'b0; an_in = '1; segment_in = 7'h7F; dp_in = 1'b1;
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   initial begin
      int base;
      clr_err = 1'b0;
      do_reset();
      check("reset.digits", digits_o, 0);
      check("reset.dp", dp_o, 0);
      check("reset.ok", digit_ok_o, 0);
      check("reset.frame", frame_valid_o, 0);
      check("reset.err", err_o, 0);

      // Scan "1234"
      scan_pat(SEG[1], SEG[2], SEG[3], SEG[4], 4'hF, 16);
      phase_check("scan1234");
      check("scan1234.const", digits_o, 16'h4321);
      check("scan1234.okconst", digit_ok_o, 4'hF);

      // Glitch: 8 for two cycles, then 3 for ten under digit 2
      drive(AN[0], SEG[1], 1'b1, 16);
      drive(AN[1], SEG[2], 1'b1, 16);
      drive(AN[2], SEG[8], 1'b1, 2);
      drive(AN[2], SEG[3], 1'b1, 10);
      drive(AN[3], SEG[4], 1'b1, 16);
      phase_check("glitch");
      check("glitch.const", digits_o, 16'h4321);

      // Illegal pattern on digit 1, then clear
      scan_pat(SEG[1], 7'h7F, SEG[3], SEG[4], 4'hF, 16);
      phase_check("illegal");
      check("illegal.okconst", digit_ok_o, 4'b1101);
      check("illegal.nibble", digits_o[7:4], 4'hF);
      clr_err = 1'b1; m_err = 1'b0;
      @(negedge clk);
      clr_err = 1'b0;
      check("clr_err", err_o, 0);

      // Multi-anode mid-scan
      base = pulses;
      drive(AN[0], SEG[7], 1'b1, 16);
      drive(AN[1], SEG[6], 1'b1, 16);
      drive(4'b1100, SEG[5], 1'b1, 5);
      phase_check("multi");
      check("multi.nopulse", pulses, base);
      scan_pat(SEG[9], SEG[8], SEG[7], SEG[6], 4'hF, 16);
      phase_check("multi.rescan");
      check("multi.onepulse", pulses, base + 1);

      // dp low on digit 2, reset mid-scan, full rescan
      scan_pat(SEG[0], SEG[5], SEG[2], SEG[9], 4'b1011, 16);
      phase_check("dp");
      check("dp.const", dp_o, 4'b1011);
      drive(AN[0], SEG[3], 1'b0, 16);
      drive(AN[1], SEG[3], 1'b1, 16);
      do_reset();
      check("midreset.digits", digits_o, 0);
      base = pulses;
      scan_pat(SEG[4], SEG[3], SEG[2], SEG[1], 4'b0101, 16);
      phase_check("rescan");
      check("rescan.onepulse", pulses, base + 1);

      // Dwell shorter than the settle window
      do_reset();
      base = pulses;
      scan_pat(SEG[1], SEG[2], SEG[3], SEG[4], 4'hF, 3);
      scan_pat(SEG[5], SEG[6], SEG[7], SEG[8], 4'hF, 3);
      phase_check("short");
      check("short.nopulse", pulses, base);
      check("short.digits", digits_o, 0);

      // Randomized scans with mixed dwell lengths
      for (int r = 0; r < 8; r++) begin
         for (int d = 0; d < N; d++) begin
            drive(AN[d], SEG[$urandom_range(9, 0)], 1'($urandom_range(1, 0)),
                  int'($urandom_range(10, 2)));
         end
         phase_check($sformatf("rand%0d", r));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/ssd_capture.md
Name: ssd_capture

Overview:
- Receive-side monitor for the multiplexed seven-segment display bus: the reverse of the hex-to-segment encoder.
- Samples the active-low segment, dp and anode lines and decodes each stable segment pattern back to a BCD digit.
- Assembles one complete scan of all digits into a frame and publishes it with a one-cycle strobe.
- Used on-chip for stopwatch self-check and as a bench-side scoreboard tap.

Parameters:
- N_DIGITS, 4, number of multiplexed digit positions (anode lines).
- SETTLE_CYCLES, 4, consecutive identical samples (1..255) required before a digit is captured.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- segment_in  input  7  active-low segments; bit6=a ... bit0=g.
- dp_in  input  1  decimal-point line; captured raw.
- an_in  input  N_DIGITS  active-low anode enables; bit i selects digit i.
- clr_err  input  1  synchronous clear of err_o.
- digits_o  output  4*N_DIGITS  captured BCD digits; digit i at bits [4i+3:4i].
- dp_o  output  N_DIGITS  captured dp per digit.
- digit_ok_o  output  N_DIGITS  1 = digit i held a recognised pattern in the last frame.
- frame_valid_o  output  1  one-cycle strobe; all outputs above updated this cycle.
- err_o  output  1  sticky error flag.

Behaviour:
- Reset, asynchronous: digits_o=0, dp_o=0, digit_ok_o=0, frame_valid_o=0, err_o=0; FSM=IDLE; settle counter=0; seen mask=0; shadow registers=0.
- Inputs are registered once; all decisions use the registered sample, so detection latency is +1 cycle.
- Decode table, exact match on 7 bits:
  - 0000001=0, 1001111=1, 0010010=2, 0000110=3, 1001100=4
  - 0100100=5, 0100000=6, 0001101=7, 0000000=8, 0000100=9
  - Any other pattern decodes to 4'hF with ok=0.
- Anode qualification:
  - "Single" = exactly one bit of an_in low.
  - All bits high = blank, which is legal.
  - Two or more bits low = multi; sets err_o and forces the FSM to IDLE.
- FSM:
  - IDLE: on a single anode, load anode index, pattern and dp; cnt=1; go to SETTLE.
  - SETTLE: if anode, pattern and dp are unchanged, cnt++. When cnt reaches SETTLE_CYCLES, write shadow digit/ok/dp for the index, set seen[index], go to HOLD. If anything changes, reload with the new values and set cnt=1; on blank or multi, go to IDLE.
  - HOLD: stay while the inputs are unchanged. When the anode changes to another single anode, go to SETTLE with the new values. On blank, go to IDLE. On a pattern change under the same anode, go to SETTLE and recapture; that digit's shadow is overwritten.
  - Capture timing: a digit is captured on the cycle cnt reaches SETTLE_CYCLES, i.e. SETTLE_CYCLES cycles after its first registered sample.
- Frame assembly:
  - When a capture makes seen all-ones, on the same clock edge: copy the shadow (including the new digit) to digits_o, dp_o and digit_ok_o; pulse frame_valid_o; clear seen.
  - A recapture of an already-seen digit before frame completion overwrites the shadow and does not advance the frame.
  - Outputs hold their values between frames.
- err_o:
  - Set by a multi-anode sample or by any capture with ok=0.
  - Cleared only by clr_err or rst_n. If a set event and clr_err occur in the same cycle, set wins.
- Counter saturates at SETTLE_CYCLES; no wrap.
- Reset mid-scan discards the partial frame. No frame_valid_o pulse is issued until a full new scan completes.

Test Plan:
- Scan "1234", SETTLE_CYCLES=4, 16 cycles per digit, anodes cycling 1110→1101→1011→0111 → one frame_valid_o pulse after the digit-3 capture; digits_o=16'h4321 (digit 0 = 1); digit_ok_o=4'hF; err_o=0.
- Glitch: digit 2 shows 0000000 for 2 cycles, then 0000110 for 10 cycles → captured value 3, not 8; frame digits_o=16'h4321 unchanged.
- Illegal pattern 1111111 on digit 1, stable → frame digit_ok_o=4'b1101, digits_o[7:4]=4'hF, err_o=1; clr_err pulse → err_o=0.
- an_in=1100 for 5 cycles mid-scan → err_o=1; FSM returns to IDLE; no frame until all four digits are seen again.
- dp_in low on digit 2 only → dp_o=4'b1011, with dp_o[i] following the raw dp_in level sampled for digit i; rst_n asserted mid-scan, then a full rescan → exactly one frame_valid_o pulse, after the new complete scan.
- Anode dwell shorter than SETTLE_CYCLES (3 cycles per digit) → no capture and no frame_valid_o; outputs hold their reset values.
